bitty_core_param: RTL and testbench



---
 rtl/bitty_core_param_if.sv | 25 ++
 rtl/bitty_core_param.sv | 150 +++++++++++++++
 tb/tb_bitty_core_param.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_core_param_if.sv
// Bus bundle for the bitty core: start handshake, instruction word,
// debug register read port and completion status.
interface bitty_core_param_if #(
    parameter int WIDTH = 16
);
    logic             run;
    logic [15:0]      instruction;
    logic [2:0]       dbg_sel;
    logic [WIDTH-1:0] dbg_data;
    logic             busy;
    logic             done;
    logic             illegal;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output run, instruction, dbg_sel,
        input  dbg_data, busy, done, illegal, flag_z, flag_c
    );

    modport slave (
        input  run, instruction, dbg_sel,
        output dbg_data, busy, done, illegal, flag_z, flag_c
    );
endinterface

// File: rtl/bitty_core_param.sv
// Multi-cycle bitty processor core: eight WIDTH-bit registers, a small ALU,
// and a fixed IDLE -> LOADA -> EXEC -> WB sequence per instruction.
module bitty_core_param #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input logic               clk,
    input logic               reset,
    bitty_core_param_if.slave bus
);

    generate
        if (NREGS != 8) begin : g_bad_nregs
            $error("bitty_core_param: NREGS must be exactly 8");
        end
        if ((WIDTH < 10) || (WIDTH > 32)) begin : g_bad_width
            $error("bitty_core_param: WIDTH must lie in 10..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADA = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t           r_state;
    logic [15:0]      r_instr;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_illegal;
    logic             r_flag_z;
    logic             r_flag_c;

    logic [2:0]       w_rx;
    logic [2:0]       w_ry;
    logic [1:0]       w_fmt;
    logic [3:0]       w_op;
    logic             w_illegal;
    logic [WIDTH-1:0] w_b_src;
    logic [WIDTH-1:0] w_imm10;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu;
    logic             w_alu_carry;

    assign w_rx      = r_instr[15:13];
    assign w_ry      = r_instr[12:10];
    assign w_fmt     = r_instr[1:0];
    assign w_op      = (w_fmt == 2'b00) ? r_instr[5:2] : {1'b0, r_instr[4:2]};
    assign w_illegal = (w_fmt == 2'b11) || ((w_fmt == 2'b00) && (r_instr[5:2] > 4'd8));
    assign w_b_src   = (w_fmt == 2'b00) ? r_regs[w_ry] : WIDTH'(r_instr[12:5]);
    assign w_imm10   = WIDTH'(r_instr[12:3]);
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};

    // Shift distances of WIDTH or more clear the result rather than wrapping.
    always_comb begin
        w_alu       = '0;
        w_alu_carry = 1'b0;
        case (w_op)
            4'd0: begin
                w_alu       = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            4'd1: begin
                w_alu       = r_a - r_b;
                w_alu_carry = (r_a >= r_b);
            end
            4'd2: w_alu = r_a & r_b;
            4'd3: w_alu = r_a | r_b;
            4'd4: w_alu = r_a ^ r_b;
            4'd5: w_alu = ~r_a;
            4'd6: w_alu = (32'(r_b) >= WIDTH) ? '0 : (r_a << r_b);
            4'd7: w_alu = (32'(r_b) >= WIDTH) ? '0 : (r_a >> r_b);
            4'd8: w_alu = r_b;
            default: w_alu = '0;
        endcase
    end

    // Writeback lands on the edge leaving WB; the following cycle is the
    // done cycle, still busy, and run is only sampled once it has passed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_instr   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_carry   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_done) begin
                        r_done    <= 1'b0;
                        r_illegal <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (bus.run) begin
                        r_instr <= bus.instruction;
                        r_busy  <= 1'b1;
                        r_state <= LOADA;
                    end
                end
                LOADA: begin
                    r_a     <= r_regs[w_rx];
                    r_b     <= w_b_src;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_c     <= (w_fmt == 2'b10) ? w_imm10 : w_alu;
                    r_carry <= w_alu_carry;
                    r_state <= WB;
                end
                WB: begin
                    if (!w_illegal) begin
                        r_regs[w_rx] <= r_c;
                        if (w_fmt != 2'b10) begin
                            r_flag_z <= (r_c == '0);
                            r_flag_c <= r_carry;
                        end
                    end
                    r_done    <= 1'b1;
                    r_illegal <= w_illegal;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dbg_data = r_regs[bus.dbg_sel];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.illegal  = r_illegal;
    assign bus.flag_z   = r_flag_z;
    assign bus.flag_c   = r_flag_c;

endmodule

// File: tb/tb_bitty_core_param.sv
// Self-checking bench for bitty_core_param: directed scenarios plus random
// instructions compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bitty_core_param;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   compareCount;
    int   failCount;

    logic [WIDTH-1:0] mRegs [8];
    bit               mZ;
    bit               mC;

    bitty_core_param_if #(.WIDTH(WIDTH)) bus ();

    bitty_core_param #(.WIDTH(WIDTH), .NREGS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_sel = 3'(i);
            #1;
            checkOutput($sformatf("%s_R%0d", tag, i), 32'(bus.dbg_data), 32'(mRegs[i]));
        end
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_z"}, 32'(bus.flag_z), 32'(mZ));
        checkOutput({tag, "_c"}, 32'(bus.flag_c), 32'(mC));
    endtask

    task automatic readReg(input int idx, output logic [WIDTH-1:0] val);
        bus.dbg_sel = 3'(idx);
        #1;
        val = bus.dbg_data;
    endtask

    function automatic logic [15:0] enc00(input logic [2:0] rx, input logic [2:0] ry, input logic [3:0] op);
        return {rx, ry, 4'b0000, op, 2'b00};
    endfunction

    function automatic logic [15:0] enc01(input logic [2:0] rx, input logic [7:0] imm, input logic [2:0] op);
        return {rx, imm, op, 2'b01};
    endfunction

    function automatic logic [15:0] enc10(input logic [2:0] rx, input logic [9:0] imm);
        return {rx, imm, 1'b0, 2'b10};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mRegs[i] = '0;
        mZ = 1'b0;
        mC = 1'b0;
    endtask

    // Architectural effect of one instruction, from the ISA rules.
    task automatic modelExec(input logic [15:0] ins, output bit isIllegal);
        longint a, b, res, mask;
        int     fmt, rx, ry, op;
        bit     carry;
        mask      = (longint'(1) << WIDTH) - 1;
        fmt       = int'(ins[1:0]);
        rx        = int'(ins[15:13]);
        ry        = int'(ins[12:10]);
        isIllegal = 1'b0;
        carry     = 1'b0;
        res       = 0;
        if (fmt == 3) begin
            isIllegal = 1'b1;
            return;
        end
        if (fmt == 2) begin
            mRegs[rx] = WIDTH'(ins[12:3]);
            return;
        end
        a  = longint'(mRegs[rx]);
        b  = (fmt == 0) ? longint'(mRegs[ry]) : longint'(ins[12:5]);
        op = (fmt == 0) ? int'(ins[5:2]) : int'(ins[4:2]);
        case (op)
            0: begin res = a + b; carry = (res > mask); end
            1: begin res = a - b; carry = (a >= b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = ~a;
            6: res = (b >= WIDTH) ? 0 : (a << b);
            7: res = (b >= WIDTH) ? 0 : (a >> b);
            8: res = b;
            default: begin
                isIllegal = 1'b1;
                return;
            end
        endcase
        res       = res & mask;
        mRegs[rx] = res[WIDTH-1:0];
        mZ        = (res == 0);
        mC        = carry;
    endtask

    // Issues one instruction from idle and checks every cycle up to the return to idle.
    task automatic applyStimulus(input logic [15:0] ins, input bit holdRun);
        bit               expIllegal;
        logic [WIDTH-1:0] oldRx;
        int               rx;
        rx              = int'(ins[15:13]);
        oldRx           = mRegs[rx];
        bus.run         = 1'b1;
        bus.instruction = ins;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busyAfterAccept", 32'(bus.busy), 32'd1);
        checkOutput("doneK0", 32'(bus.done), 32'd0);
        if (!holdRun) bus.run = 1'b0;
        bus.instruction = 16'($urandom);
        @(negedge clk);
        checkOutput("doneK1", 32'(bus.done), 32'd0);
        @(negedge clk);
        checkOutput("doneK2", 32'(bus.done), 32'd0);
        bus.dbg_sel = ins[15:13];
        #1;
        checkOutput("noEarlyWrite", 32'(bus.dbg_data), 32'(oldRx));
        @(negedge clk);
        modelExec(ins, expIllegal);
        checkOutput("doneK3", 32'(bus.done), 32'd1);
        checkOutput("busyK3", 32'(bus.busy), 32'd1);
        checkOutput("illegalK3", 32'(bus.illegal), 32'(expIllegal));
        checkFlags("flagsK3");
        checkAllRegs("regsK3");
        @(negedge clk);
        checkOutput("busyK4", 32'(bus.busy), 32'd0);
        checkOutput("doneK4", 32'(bus.done), 32'd0);
        checkOutput("illegalK4", 32'(bus.illegal), 32'd0);
        bus.run = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] val;
        logic [15:0]      ins;
        int               fmtSel;
        compareCount    = 0;
        failCount       = 0;
        reset           = 1'b0;
        bus.run         = 1'b0;
        bus.instruction = '0;
        bus.dbg_sel     = '0;
        modelReset();

        repeat (3) @(negedge clk);
        reset = 1'b1;
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstDone", 32'(bus.done), 32'd0);
        checkOutput("rstIllegal", 32'(bus.illegal), 32'd0);
        checkFlags("rstFlags");
        checkAllRegs("rstRegs");

        applyStimulus(enc10(3'd1, 10'h3FF), 1'b0);
        readReg(1, val);
        checkOutput("loadR1", 32'(val), 32'h03FF);
        applyStimulus(enc00(3'd1, 3'd1, 4'd0), 1'b0);
        readReg(1, val);
        checkOutput("addR1R1", 32'(val), 32'h07FE);

        applyStimulus(enc00(3'd0, 3'd0, 4'd5), 1'b0);
        readReg(0, val);
        checkOutput("notR0", 32'(val), 32'hFFFF);
        applyStimulus(enc01(3'd0, 8'd1, 3'd0), 1'b0);
        readReg(0, val);
        checkOutput("addImmWrap", 32'(val), 32'h0000);
        checkOutput("addImmWrapZ", 32'(bus.flag_z), 32'd1);
        checkOutput("addImmWrapC", 32'(bus.flag_c), 32'd1);
        applyStimulus(enc10(3'd2, 10'h155), 1'b0);
        applyStimulus(enc00(3'd2, 3'd2, 4'd1), 1'b0);
        readReg(2, val);
        checkOutput("subSelf", 32'(val), 32'h0000);
        checkOutput("subSelfC", 32'(bus.flag_c), 32'd1);

        applyStimulus(enc10(3'd1, 10'd1), 1'b0);
        applyStimulus(enc01(3'd1, 8'd16, 3'd6), 1'b0);
        readReg(1, val);
        checkOutput("shl16", 32'(val), 32'h0000);
        applyStimulus(enc10(3'd1, 10'd1), 1'b0);
        applyStimulus(enc01(3'd1, 8'd15, 3'd6), 1'b0);
        readReg(1, val);
        checkOutput("shl15", 32'(val), 32'h8000);
        applyStimulus(enc01(3'd1, 8'd15, 3'd7), 1'b0);
        readReg(1, val);
        checkOutput("shr15", 32'(val), 32'h0001);

        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(enc00(3'd4, 3'd5, 4'd12), 1'b1);
        applyStimulus(enc01(3'd5, 8'hA5, 3'd3), 1'b1);

        applyStimulus(enc10(3'd3, 10'h055), 1'b0);
        bus.run         = 1'b1;
        bus.instruction = enc01(3'd3, 8'h10, 3'd0);
        @(posedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("abortBusy", 32'(bus.busy), 32'd0);
        checkOutput("abortDone", 32'(bus.done), 32'd0);
        readReg(3, val);
        checkOutput("abortR3", 32'(val), 32'h0000);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("noDoneAfterAbort", 32'(bus.done), 32'd0);
        end
        applyStimulus(enc01(3'd3, 8'h10, 3'd0), 1'b0);
        readReg(3, val);
        checkOutput("addAfterAbort", 32'(val), 32'h0010);

        for (int n = 0; n < 40; n++) begin
            ins    = 16'($urandom);
            fmtSel = int'($urandom_range(0, 9));
            if (fmtSel < 4) begin
                ins[1:0] = 2'b00;
                ins[5:2] = 4'($urandom_range(0, 10));
            end else if (fmtSel < 7) begin
                ins[1:0] = 2'b01;
            end else if (fmtSel < 9) begin
                ins[1:0] = 2'b10;
            end else begin
                ins[1:0] = 2'b11;
            end
            applyStimulus(ins, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
